// File: rtl/servo_pkg.sv
// servo_pkg: register map, reset constants and width helpers shared by the
// servo PWM sequencer.
package servo_pkg;

    // Avalon word addresses
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_PULSE0 = 2'd2;
    localparam logic [1:0] REG_PULSE1 = 2'd3;

    // Neutral servo position loaded into both width registers at reset
    localparam logic [15:0] WIDTH_RESET_US = 16'd1500;

    // STATUS layout
    localparam int STATUS_PEND_LSB = 0;
    localparam int STATUS_TOG_BIT  = 8;

    // Limit a requested width to the legal servo range
    function automatic logic [15:0] clamp_us(input logic [15:0] w,
                                             input logic [15:0] lo,
                                             input logic [15:0] hi);
        if (w < lo) begin
            return lo;
        end else if (w > hi) begin
            return hi;
        end
        return w;
    endfunction

    // Move cur toward tgt by at most step
    function automatic logic [15:0] slew_toward(input logic [15:0] cur,
                                                input logic [15:0] tgt,
                                                input logic [15:0] step);
        if (tgt > cur) begin
            return (tgt - cur > step) ? cur + step : tgt;
        end
        return (cur - tgt > step) ? cur - step : tgt;
    endfunction

endpackage

// File: rtl/servo_pwm_sequencer_us_tick_gen.sv
// us_tick_gen: divides the system clock down to a one-cycle pulse every
// microsecond. CLK_HZ must be a whole multiple of 1 MHz.
module us_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == TERMINAL);

    // Prescaler: count 0..DIV-1 and restart after the terminal count
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples the pre-edge values of its neighbours.
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/servo_pwm_sequencer.sv
// servo_pwm_sequencer: Avalon-MM slave driving two hobby-servo PWM outputs
// inside a common PERIOD_US frame, channel 1 delayed by STAGGER_US.
// Widths written over the bus are held pending and committed at frame start.
// Build option SERVO_SLEW_EN: each commit moves the active width toward the
// target by at most SLEW_US instead of jumping straight to it.
module servo_pwm_sequencer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int PERIOD_US  = 20000,
    parameter int MIN_US     = 1000,
    parameter int MAX_US     = 2000,
    parameter int STAGGER_US = 2500,
    parameter int SLEW_US    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [1:0]  servo_out
);

    import servo_pkg::*;

    localparam int FW = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(PERIOD_US - 1);
    localparam logic [15:0]   MIN16      = 16'(MIN_US);
    localparam logic [15:0]   MAX16      = 16'(MAX_US);

    logic          tick;
    logic          frame_wrap;
    logic [FW-1:0] frame_us;
    logic          frame_tog;
    logic [1:0]    ctrl;
    logic [1:0]    en_act;
    logic [1:0]    en_next;
    logic [1:0]    pend;
    logic [1:0]    pend_next;
    logic [1:0]    wr_pulse;
    logic          wr_ctrl;
    logic [1:0]    window;
    logic [31:0]   rd_mux;
    logic [15:0]   width_pend [2];
    logic [15:0]   width_act  [2];
    logic [15:0]   target     [2];
    logic [15:0]   width_next [2];

    // Upper write-data bits have no register behind them
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:16];

    us_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // The edge that wraps frame_us back to 0 is the commit edge
    assign frame_wrap  = tick && (frame_us == FRAME_LAST);
    assign wr_ctrl     = write && (address == REG_CTRL);
    assign wr_pulse[0] = write && (address == REG_PULSE0);
    assign wr_pulse[1] = write && (address == REG_PULSE1);

    // Frame position in microseconds
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_us <= '0;
        end else if (frame_wrap) begin
            frame_us <= '0;
        end else if (tick) begin
            frame_us <= frame_us + 1'b1;
        end
    end

    // Next committed widths, enables and pending flags
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        en_next   = en_act;
        pend_next = pend;
        for (int ch = 0; ch < 2; ch++) begin
            target[ch] = clamp_us(width_pend[ch], MIN16, MAX16);
`ifdef SERVO_SLEW_EN
            width_next[ch] = slew_toward(width_act[ch], target[ch], 16'(SLEW_US));
`else
            width_next[ch] = target[ch];
`endif
            // A bus write in the commit cycle re-arms the flag for the next frame
            if (frame_wrap && (width_next[ch] == target[ch])) begin
                pend_next[ch] = 1'b0;
            end
            if (wr_pulse[ch]) begin
                pend_next[ch] = 1'b1;
            end
        end
        if (frame_wrap) begin
            en_next = ctrl;
        end
        // Disabling a channel acts immediately; enabling waits for a commit
        if (wr_ctrl) begin
            en_next = en_next & writedata[1:0];
        end
    end

`ifndef SERVO_SLEW_EN
    // Rate limit only exists in the slew build
    logic unused_slew;
    assign unused_slew = ^16'(SLEW_US);
`endif

    // Bus-visible registers and the frame-start commit
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl      <= '0;
            en_act    <= '0;
            pend      <= '0;
            frame_tog <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                width_pend[ch] <= WIDTH_RESET_US;
                width_act[ch]  <= WIDTH_RESET_US;
            end
        end else begin
            en_act <= en_next;
            pend   <= pend_next;
            if (wr_ctrl) begin
                ctrl <= writedata[1:0];
            end
            if (frame_wrap) begin
                frame_tog <= ~frame_tog;
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (frame_wrap) begin
                    width_act[ch] <= width_next[ch];
                end
                if (wr_pulse[ch]) begin
                    width_pend[ch] <= writedata[15:0];
                end
            end
        end
    end

    // Pulse windows: [off, off + width) measured from frame start
    always_comb begin
        window = '0;
        for (int ch = 0; ch < 2; ch++) begin
            window[ch] = en_act[ch]
                && (32'(frame_us) >= 32'(ch * STAGGER_US))
                && (32'(frame_us) <  32'(ch * STAGGER_US) + 32'(width_act[ch]));
        end
    end

    // Registered PWM outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            servo_out <= '0;
        end else begin
            servo_out <= window;
        end
    end

    // Read mux; reads see register contents from before a same-cycle write
    always_comb begin
        rd_mux = '0;
        case (address)
            REG_CTRL: rd_mux[1:0] = ctrl;
            REG_STATUS: begin
                rd_mux[STATUS_PEND_LSB +: 2] = pend;
                rd_mux[STATUS_TOG_BIT]       = frame_tog;
            end
            REG_PULSE0: rd_mux[15:0] = width_pend[0];
            REG_PULSE1: rd_mux[15:0] = width_pend[1];
            default:    rd_mux = '0;
        endcase
    end

    // Read data register, held between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_servo_pwm_sequencer.sv
// Self-checking bench for servo_pwm_sequencer. A 2 MHz clock and a 4600 us
// frame keep whole-frame scenarios short. Define SERVO_SLEW_EN consistently
// for RTL and bench to exercise the slew build.
module tb_servo_pwm_sequencer;

    localparam int CLK_HZ     = 2_000_000;
    localparam int DIV        = CLK_HZ / 1_000_000;
    localparam int PERIOD_US  = 4600;
    localparam int MIN_US     = 1000;
    localparam int MAX_US     = 2000;
    localparam int STAGGER_US = 2500;
    localparam int SLEW_US    = 10;
    localparam int F          = DIV * PERIOD_US;   // cycles per frame

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [1:0]  servo_out;

    always #5 clk = ~clk;

    servo_pwm_sequencer #(
        .CLK_HZ    (CLK_HZ),
        .PERIOD_US (PERIOD_US),
        .MIN_US    (MIN_US),
        .MAX_US    (MAX_US),
        .STAGGER_US(STAGGER_US),
        .SLEW_US   (SLEW_US)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .read     (read),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .servo_out(servo_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          n;                 // clock edges since reset released
    logic [1:0]  m_ctrl, m_en, m_pend, m_out, prev_out;
    int          m_wact [2];
    int          m_wpend [2];
    logic        m_tog;
    logic [31:0] m_rd;
    int          f_us, off, new_w;
    int          rise_n [2][16];
    int          wid    [2][16];
    int          npulse [2];

    function automatic int clamp_i(input int w);
        if (w < MIN_US) return MIN_US;
        if (w > MAX_US) return MAX_US;
        return w;
    endfunction

    function automatic int commit_width(input int cur, input int req);
        int t = clamp_i(req);
`ifdef SERVO_SLEW_EN
        if (t > cur + SLEW_US) return cur + SLEW_US;
        if (t < cur - SLEW_US) return cur - SLEW_US;
`endif
        return t;
    endfunction

    function automatic logic [31:0] reg_value(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_ctrl};
            2'd1:    return {23'd0, m_tog, 6'd0, m_pend};
            2'd2:    return 32'(m_wpend[0]);
            default: return 32'(m_wpend[1]);
        endcase
    endfunction

    initial begin
        npulse[0] = 0;
        npulse[1] = 0;
        prev_out  = '0;
    end

    // Model step on every edge, then compare the DUT just after the edge
    always @(posedge clk) begin
        if (reset) begin
            n = 0;
            m_ctrl = '0; m_en = '0; m_pend = '0; m_tog = 1'b0;
            m_rd = '0; m_out = '0;
            m_wact[0] = 1500; m_wact[1] = 1500;
            m_wpend[0] = 1500; m_wpend[1] = 1500;
        end else begin
            f_us = (n / DIV) % PERIOD_US;
            for (int ch = 0; ch < 2; ch++) begin
                off = ch * STAGGER_US;
                m_out[ch] = m_en[ch] && (f_us >= off) && (f_us < off + m_wact[ch]);
            end
            if (read) m_rd = reg_value(address);
            n++;
            if (n % F == 0) begin
                for (int ch = 0; ch < 2; ch++) begin
                    new_w = commit_width(m_wact[ch], m_wpend[ch]);
                    if (new_w == clamp_i(m_wpend[ch])) m_pend[ch] = 1'b0;
                    m_wact[ch] = new_w;
                end
                m_en  = m_ctrl;
                m_tog = ~m_tog;
            end
            if (write) begin
                case (address)
                    2'd0: begin
                        m_ctrl = writedata[1:0];
                        m_en   = m_en & writedata[1:0];
                    end
                    2'd2: begin m_wpend[0] = int'(writedata[15:0]); m_pend[0] = 1'b1; end
                    2'd3: begin m_wpend[1] = int'(writedata[15:0]); m_pend[1] = 1'b1; end
                    default: ;
                endcase
            end
        end
        #1;
        check("servo_out", {30'd0, servo_out}, {30'd0, m_out});
        check("readdata", readdata, m_rd);
        for (int ch = 0; ch < 2; ch++) begin
            if (servo_out[ch] && !prev_out[ch] && npulse[ch] < 16) begin
                rise_n[ch][npulse[ch]] = n;
            end else if (!servo_out[ch] && prev_out[ch] && npulse[ch] < 16) begin
                wid[ch][npulse[ch]] = n - rise_n[ch][npulse[ch]];
                npulse[ch]++;
            end
        end
        prev_out = servo_out;
    end

    // ---------------- driver ----------------
    // Wait so the next transaction is sampled at edge number k
    task automatic at_cycle(input int k);
        int guard = 0;
        while (n < k - 1 && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    logic [31:0] rd;
    logic [1:0]  ra;
    int          e_w0_1, e_w0_3, e_w1_1, e_w1_2;
    logic [31:0] e_stat2, e_stat3;

    initial begin
`ifdef SERVO_SLEW_EN
        e_w0_1 = 3020; e_w0_3 = 3020; e_w1_1 = 2980; e_w1_2 = 3000;
        e_stat2 = 32'h003; e_stat3 = 32'h103;
`else
        e_w0_1 = 3600; e_w0_3 = 2400; e_w1_1 = 2000; e_w1_2 = 4000;
        e_stat2 = 32'h000; e_stat3 = 32'h101;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset servo_out", {30'd0, servo_out}, 32'd0);
        check("reset readdata", readdata, 32'd0);
        bus_read(2'd2, rd);  check("reset PULSE0", rd, 32'd1500);
        bus_read(2'd1, rd);  check("reset STATUS", rd, 32'd0);
        bus_read(2'd0, rd);  check("reset CTRL", rd, 32'd0);

        at_cycle(10);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_read(2'd0, rd);  check("CTRL upper bits", rd, 32'd3);

        // Frame 1: change widths while ch0 is mid-pulse
        at_cycle(F + 1000);
        bus_write(2'd2, 32'd1800);
        bus_read(2'd1, rd);  check("STATUS pend0 mid-frame", rd, 32'h101);
        bus_write(2'd3, 32'd500);

        // Frame 2: status after commit, simultaneous read+write
        at_cycle(2 * F + 100);
        bus_read(2'd1, rd);  check("STATUS after commit", rd, e_stat2);
        address = 2'd3; writedata = 32'd2500; read = 1'b1; write = 1'b1;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        check("PULSE1 read during write", readdata, 32'd500);
        bus_read(2'd3, rd);  check("PULSE1 readback unclamped", rd, 32'd2500);

        // Write landing exactly on the commit edge of frame 3
        at_cycle(3 * F);
        bus_write(2'd2, 32'd1200);
        at_cycle(3 * F + 100);
        bus_read(2'd1, rd);  check("STATUS write at commit", rd, e_stat3);

        // Disable ch0 mid-pulse, re-enable mid-frame
        at_cycle(3 * F + 1000);
        bus_write(2'd0, 32'd2);
        check("ch0 still high on write edge", {31'd0, servo_out[0]}, 32'd1);
        @(negedge clk);
        check("ch0 low one cycle after disable", {31'd0, servo_out[0]}, 32'd0);
        at_cycle(3 * F + 2000);
        bus_write(2'd0, 32'd3);

        // Random bus traffic across frames 4 and 5
        at_cycle(4 * F + 3000);
        while (n < 6 * F - 600) begin
            repeat ($urandom_range(1, 300)) @(negedge clk);
            ra        = 2'($urandom_range(0, 3));
            address   = ra;
            read      = 1'($urandom_range(0, 1));
            write     = 1'($urandom_range(0, 1));
            if (ra == 2'd0)
                writedata = $urandom;
            else if ($urandom_range(0, 3) == 0)
                writedata = 32'($urandom_range(0, 65535));
            else
                writedata = 32'($urandom_range(800, 2300));
            @(negedge clk);
            read = 1'b0; write = 1'b0;
        end

        // Reset while ch0 is high
        at_cycle(6 * F - 50);
        bus_write(2'd0, 32'd3);
        at_cycle(6 * F + 500);
        check("ch0 high before reset", {31'd0, servo_out[0]}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("outputs drop on reset", {30'd0, servo_out}, 32'd0);
        bus_write(2'd0, 32'd3);
        repeat (3000) @(negedge clk);

        // Pulse placement and widths, in clock cycles
        check("ch0 rise frame1", rise_n[0][0], F + 1);
        check("ch0 width frame1", wid[0][0], 1500 * DIV);
        check("ch1 rise frame1", rise_n[1][0], F + STAGGER_US * DIV + 1);
        check("ch1 width frame1", wid[1][0], 1500 * DIV);
        check("ch0 rise frame2", rise_n[0][1], 2 * F + 1);
        check("ch0 width frame2", wid[0][1], e_w0_1);
        check("ch1 width frame2", wid[1][1], e_w1_1);
        check("ch0 width cut by disable", wid[0][2], 1000);
        check("ch1 width frame3", wid[1][2], e_w1_2);
        check("ch0 rise after re-enable", rise_n[0][3], 4 * F + 1);
        check("ch0 width frame4", wid[0][3], e_w0_3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
